// File: rtl/alu_seq.sv
// Registered, handshaked ALU with single-cycle logic/arith ops and an iterative
// unsigned shift-add multiplier (MUL low half, MULHU high half).
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             illegal_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SRL   = 4'd3;
    localparam logic [3:0] OP_SRA   = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     result_reg, result_next;
    logic                 zero_reg, zero_next;
    logic                 carry_reg, carry_next;
    logic                 overflow_reg, overflow_next;
    logic                 illegal_reg, illegal_next;
    logic                 out_valid_reg, out_valid_next;
    logic [2*WIDTH-1:0]   prod_reg, prod_next;
    logic [WIDTH-1:0]     mcand_reg, mcand_next;
    logic [CW-1:0]        count_reg, count_next;
    logic                 mulhu_reg, mulhu_next;

    logic                 accept;
    logic                 is_mul;
    logic                 sub_sel;
    logic [WIDTH-1:0]     b_eff;
    logic [WIDTH:0]       sum_full;
    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry;
    logic                 alu_ovf;
    logic                 alu_illegal;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_step;
    logic [WIDTH-1:0]     mul_res;

    assign in_ready_o  = (state_reg == IDLE) && (!out_valid_reg || out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign is_mul      = (op_i == OP_MUL) || (op_i == OP_MULHU);

    assign out_valid_o = out_valid_reg;
    assign result_o    = result_reg;
    assign zero_o      = zero_reg;
    assign carry_o     = carry_reg;
    assign overflow_o  = overflow_reg;
    assign illegal_o   = illegal_reg;

    // Shared adder: SUB is A + ~B + 1, so carry-out doubles as "no borrow".
    assign sub_sel  = (op_i == OP_SUB);
    assign b_eff    = sub_sel ? ~operand_b_i : operand_b_i;
    assign sum_full = {1'b0, operand_a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
    assign shamt    = operand_b_i[SHW-1:0];

    always_comb begin
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (op_i)
            OP_ADD, OP_SUB: begin
                alu_res   = sum_full[WIDTH-1:0];
                alu_carry = sum_full[WIDTH];
                alu_ovf   = (operand_a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                            (sum_full[WIDTH-1] != operand_a_i[WIDTH-1]);
            end
            OP_SLL:  alu_res = operand_a_i << shamt;
            OP_SRL:  alu_res = operand_a_i >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(operand_a_i) >>> shamt);
            OP_XOR:  alu_res = operand_a_i ^ operand_b_i;
            OP_OR:   alu_res = operand_a_i | operand_b_i;
            OP_AND:  alu_res = operand_a_i & operand_b_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a_i) < $signed(operand_b_i))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (operand_a_i < operand_b_i)};
            OP_MUL, OP_MULHU: alu_res = '0;
            default: alu_illegal = 1'b1;
        endcase
    end

    // Upper half accumulates, lower half holds the remaining multiplier bits.
    assign mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} +
                       (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
    assign prod_step = {mul_sum, prod_reg[WIDTH-1:1]};
    assign mul_res   = mulhu_reg ? prod_step[2*WIDTH-1:WIDTH] : prod_step[WIDTH-1:0];

    always_comb begin
        state_next     = state_reg;
        result_next    = result_reg;
        zero_next      = zero_reg;
        carry_next     = carry_reg;
        overflow_next  = overflow_reg;
        illegal_next   = illegal_reg;
        out_valid_next = out_valid_reg;
        prod_next      = prod_reg;
        mcand_next     = mcand_reg;
        count_next     = count_reg;
        mulhu_next     = mulhu_reg;
        case (state_reg)
            IDLE: begin
                if (out_valid_reg && out_ready_i) begin
                    out_valid_next = 1'b0;
                end
                if (accept) begin
                    if (is_mul) begin
                        state_next     = MUL_BUSY;
                        prod_next      = {{WIDTH{1'b0}}, operand_b_i};
                        mcand_next     = operand_a_i;
                        count_next     = CW'(WIDTH);
                        mulhu_next     = (op_i == OP_MULHU);
                        out_valid_next = 1'b0;
                    end else begin
                        result_next    = alu_res;
                        zero_next      = (alu_res == '0);
                        carry_next     = alu_carry;
                        overflow_next  = alu_ovf;
                        illegal_next   = alu_illegal;
                        out_valid_next = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                prod_next  = prod_step;
                count_next = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    state_next     = IDLE;
                    result_next    = mul_res;
                    zero_next      = (mul_res == '0);
                    carry_next     = 1'b0;
                    overflow_next  = 1'b0;
                    illegal_next   = 1'b0;
                    out_valid_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            prod_reg      <= '0;
            mcand_reg     <= '0;
            count_reg     <= '0;
            mulhu_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            result_reg    <= result_next;
            zero_reg      <= zero_next;
            carry_reg     <= carry_next;
            overflow_reg  <= overflow_next;
            illegal_reg   <= illegal_next;
            out_valid_reg <= out_valid_next;
            prod_reg      <= prod_next;
            mcand_reg     <= mcand_next;
            count_reg     <= count_next;
            mulhu_reg     <= mulhu_next;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32): single-cycle ops, flags, multiplier
// latency, back-pressure, streaming and reset during a multiply.
module tb_alu_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        carry_o;
    logic        overflow_o;
    logic        illegal_o;

    int pass_count  = 0;
    int check_count = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .carry_o     (carry_o),
        .overflow_o  (overflow_o),
        .illegal_o   (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // Presents one request for one edge; called at posedge+1 with in_ready_o high.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid_i  = 1'b1;
        op_i        = op;
        operand_a_i = a;
        operand_b_i = b;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        $display("txn op=%0d a=%08h b=%08h -> valid=%0b result=%08h z=%0b c=%0b v=%0b ill=%0b",
                 op, a, b, out_valid_o, result_o, zero_o, carry_o, overflow_o, illegal_o);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_count++; if ({out_valid_o, result_o} !== 33'd0) $display("FAIL reset_out valid/result=%0b/%08h want 0/0", out_valid_o, result_o); else pass_count++;
        check_count++; if ({zero_o, carry_o, overflow_o, illegal_o} !== 4'b0000) $display("FAIL reset_flags got %04b want 0000", {zero_o, carry_o, overflow_o, illegal_o}); else pass_count++;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_count++; if (in_ready_o !== 1'b1) $display("FAIL reset_ready got %0b want 1", in_ready_o); else pass_count++;
    endtask

    task automatic test_addsub();
        send(4'd0, 32'hFFFFFFFF, 32'h00000001);
        check_count++; if (out_valid_o !== 1'b1 || result_o !== 32'h0) $display("FAIL add_wrap valid/result=%0b/%08h want 1/00000000", out_valid_o, result_o); else pass_count++;
        check_count++; if ({zero_o, carry_o, overflow_o} !== 3'b110) $display("FAIL add_wrap_flags zco=%03b want 110", {zero_o, carry_o, overflow_o}); else pass_count++;
        send(4'd1, 32'h80000000, 32'h00000001);
        check_count++; if (result_o !== 32'h7FFFFFFF) $display("FAIL sub_ovf result=%08h want 7fffffff", result_o); else pass_count++;
        check_count++; if ({zero_o, carry_o, overflow_o} !== 3'b011) $display("FAIL sub_ovf_flags zco=%03b want 011", {zero_o, carry_o, overflow_o}); else pass_count++;
        send(4'd1, 32'h00000001, 32'h00000002);
        check_count++; if (result_o !== 32'hFFFFFFFF) $display("FAIL sub_borrow result=%08h want ffffffff", result_o); else pass_count++;
        check_count++; if ({zero_o, carry_o, overflow_o} !== 3'b000) $display("FAIL sub_borrow_flags zco=%03b want 000", {zero_o, carry_o, overflow_o}); else pass_count++;
        send(4'd0, 32'h7FFFFFFF, 32'h00000001);
        check_count++; if (result_o !== 32'h80000000 || {carry_o, overflow_o} !== 2'b01) $display("FAIL add_ovf result=%08h cv=%02b want 80000000/01", result_o, {carry_o, overflow_o}); else pass_count++;
    endtask

    task automatic test_logic();
        send(4'd4, 32'h80000000, 32'd35);
        check_count++; if (result_o !== 32'hF0000000) $display("FAIL sra result=%08h want f0000000", result_o); else pass_count++;
        send(4'd2, 32'h00000001, 32'd31);
        check_count++; if (result_o !== 32'h80000000) $display("FAIL sll result=%08h want 80000000", result_o); else pass_count++;
        send(4'd3, 32'h80000000, 32'd31);
        check_count++; if (result_o !== 32'h00000001 || carry_o !== 1'b0) $display("FAIL srl result=%08h c=%0b want 00000001/0", result_o, carry_o); else pass_count++;
        send(4'd8, 32'hFFFFFFFF, 32'h00000001);
        check_count++; if (result_o !== 32'h00000001 || zero_o !== 1'b0) $display("FAIL slt result=%08h z=%0b want 00000001/0", result_o, zero_o); else pass_count++;
        send(4'd9, 32'hFFFFFFFF, 32'h00000001);
        check_count++; if (result_o !== 32'h00000000 || zero_o !== 1'b1) $display("FAIL sltu result=%08h z=%0b want 00000000/1", result_o, zero_o); else pass_count++;
        send(4'd5, 32'hF0F0F0F0, 32'hFF00FF00);
        check_count++; if (result_o !== 32'h0FF00FF0) $display("FAIL xor result=%08h want 0ff00ff0", result_o); else pass_count++;
        send(4'd6, 32'hF0F0F0F0, 32'h0000FF00);
        check_count++; if (result_o !== 32'hF0F0FFF0) $display("FAIL or result=%08h want f0f0fff0", result_o); else pass_count++;
        send(4'd7, 32'hF0F0F0F0, 32'hFF00FF00);
        check_count++; if (result_o !== 32'hF000F000) $display("FAIL and result=%08h want f000f000", result_o); else pass_count++;
        send(4'd13, 32'h12345678, 32'h9ABCDEF0);
        check_count++; if (result_o !== 32'h0 || {illegal_o, zero_o, carry_o, overflow_o} !== 4'b1100) $display("FAIL illegal result=%08h izcv=%04b want 0/1100", result_o, {illegal_o, zero_o, carry_o, overflow_o}); else pass_count++;
        send(4'd0, 32'd1, 32'd1);
        check_count++; if (result_o !== 32'd2 || illegal_o !== 1'b0) $display("FAIL illegal_clear result=%08h ill=%0b want 2/0", result_o, illegal_o); else pass_count++;
    endtask

    task automatic test_mul();
        int busy_bad;
        // Issued while the previous result is still valid: it must drop next cycle.
        send(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF);
        busy_bad = 0;
        for (int k = 1; k < 32; k++) begin
            if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0) busy_bad++;
            @(posedge clk_i);
            #1;
        end
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0) busy_bad++;
        check_count++; if (busy_bad !== 0) $display("FAIL mul_busy bad_cycles=%0d want 0", busy_bad); else pass_count++;
        @(posedge clk_i);
        #1;
        $display("txn mul done valid=%0b result=%08h z=%0b", out_valid_o, result_o, zero_o);
        check_count++; if (out_valid_o !== 1'b1 || result_o !== 32'h00000001) $display("FAIL mul_lo valid/result=%0b/%08h want 1/00000001", out_valid_o, result_o); else pass_count++;
        check_count++; if ({zero_o, carry_o, overflow_o, illegal_o} !== 4'b0000) $display("FAIL mul_lo_flags zcvi=%04b want 0000", {zero_o, carry_o, overflow_o, illegal_o}); else pass_count++;

        send(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check_count++; if (out_valid_o !== 1'b0) $display("FAIL mul_handoff valid=%0b want 0", out_valid_o); else pass_count++;
        repeat (32) @(posedge clk_i);
        #1;
        $display("txn mulhu done valid=%0b result=%08h", out_valid_o, result_o);
        check_count++; if (out_valid_o !== 1'b1 || result_o !== 32'hFFFFFFFE) $display("FAIL mulhu valid/result=%0b/%08h want 1/fffffffe", out_valid_o, result_o); else pass_count++;

        send(4'd10, 32'h00010000, 32'h00010000);
        repeat (32) @(posedge clk_i);
        #1;
        $display("txn mul done valid=%0b result=%08h z=%0b", out_valid_o, result_o, zero_o);
        check_count++; if (out_valid_o !== 1'b1 || result_o !== 32'h0 || zero_o !== 1'b1) $display("FAIL mul_zero valid/result/z=%0b/%08h/%0b want 1/0/1", out_valid_o, result_o, zero_o); else pass_count++;

        send(4'd11, 32'h0001E240, 32'h0001E240);
        repeat (32) @(posedge clk_i);
        #1;
        check_count++; if (result_o !== 32'h00000003) $display("FAIL mulhu_mid result=%08h want 00000003", result_o); else pass_count++;
    endtask

    task automatic test_backpressure();
        int hold_bad;
        send(4'd0, 32'd10, 32'd20);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        op_i        = 4'd0;
        operand_a_i = 32'd7;
        operand_b_i = 32'd8;
        hold_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i);
            #1;
            if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || result_o !== 32'd30) hold_bad++;
        end
        check_count++; if (hold_bad !== 0) $display("FAIL bp_hold bad_cycles=%0d want 0", hold_bad); else pass_count++;
        out_ready_i = 1'b1;
        #1;
        check_count++; if (in_ready_o !== 1'b1) $display("FAIL bp_release_ready got %0b want 1", in_ready_o); else pass_count++;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        $display("txn bp release valid=%0b result=%08h", out_valid_o, result_o);
        check_count++; if (out_valid_o !== 1'b1 || result_o !== 32'd15) $display("FAIL bp_next valid/result=%0b/%08h want 1/0000000f", out_valid_o, result_o); else pass_count++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_sum [4];
        int stream_bad;
        stream_bad = 0;
        for (int k = 0; k < 4; k++) exp_sum[k] = 32'(100 * (k + 1) + k);
        for (int k = 0; k < 4; k++) begin
            send(4'd0, 32'(100 * (k + 1)), 32'(k));
            if (out_valid_o !== 1'b1 || result_o !== exp_sum[k]) stream_bad++;
        end
        check_count++; if (stream_bad !== 0) $display("FAIL stream bad_results=%0d want 0", stream_bad); else pass_count++;
        @(posedge clk_i);
        #1;
        check_count++; if (out_valid_o !== 1'b0) $display("FAIL stream_drain valid=%0b want 0", out_valid_o); else pass_count++;
    endtask

    task automatic test_reset_mid_mul();
        int idle_bad;
        send(4'd10, 32'h00001234, 32'h00005678);
        repeat (9) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        check_count++; if (out_valid_o !== 1'b0 || result_o !== 32'h0 || in_ready_o !== 1'b1) $display("FAIL rst_mul valid/result/ready=%0b/%08h/%0b want 0/0/1", out_valid_o, result_o, in_ready_o); else pass_count++;
        idle_bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk_i);
            #1;
            if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) idle_bad++;
        end
        check_count++; if (idle_bad !== 0) $display("FAIL rst_mul_abandon bad_cycles=%0d want 0", idle_bad); else pass_count++;
        send(4'd0, 32'd2, 32'd3);
        check_count++; if (out_valid_o !== 1'b1 || result_o !== 32'd5) $display("FAIL rst_add valid/result=%0b/%08h want 1/00000005", out_valid_o, result_o); else pass_count++;
    endtask

    initial begin
        in_valid_i  = 1'b0;
        op_i        = 4'd0;
        operand_a_i = '0;
        operand_b_i = '0;
        out_ready_i = 1'b1;
        rst_ni      = 1'b0;
        test_reset();
        test_addsub();
        test_logic();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
